// File: rtl/mem_port_arbiter_pkg.sv
// Shared ToastCore memory-port types: read-response owner and the tag that
// travels alongside each in-flight RAM read.
package RV32I_definitions;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } mem_owner_t;

  typedef struct packed {
    logic       valid;
    mem_owner_t owner;
  } rd_tag_t;

  // Width of the IF starvation counter; holds STARVE_MAX up to 15.
  localparam int STARVE_W = 4;

  // Drop an IF tag when a flush is active; data tags always survive.
  function automatic rd_tag_t kill_if_tag(rd_tag_t tag, logic flush_if);
    rd_tag_t t;
    t = tag;
    if (flush_if && tag.owner == OWN_IF) t.valid = 1'b0;
    return t;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and RAM-side signals of the shared memory port. The arbiter takes
// the slave view; the IF/MEM stages plus the RAM together take the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 10
);
  // Instruction-fetch requester
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  // Data (load/store) requester
  logic              d_req;
  logic              d_we;
  logic [3:0]        d_be;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  // Single-port synchronous RAM
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_tag_pipe.sv
// Shift register of {valid, owner} tags matching the RAM read latency, so each
// read response is steered back to whichever requester issued it, in order.
module mem_rd_tag_pipe
  import RV32I_definitions::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       push,
  input  mem_owner_t push_owner,
  input  logic       flush_if,
  output logic       pop_valid,
  output mem_owner_t pop_owner
);

  rd_tag_t [RD_LATENCY-1:0] stage;
  rd_tag_t                  tail;

  // Advance tags one stage per cycle; a flush strips IF tags already in flight
  // while a tag pushed in the flush cycle enters untouched.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      // NOTE: these stages are control state, not bulk storage: every one is
      // reset so no response for a pre-reset read can retire after release.
      stage <= '0;
    end else begin
      stage[0] <= rd_tag_t'{valid: push, owner: push_owner};
      for (int i = 1; i < RD_LATENCY; i++) begin
        stage[i] <= kill_if_tag(stage[i-1], flush_if);
      end
    end
  end

  // The retiring tag is also subject to a flush in its final cycle.
  assign tail      = kill_if_tag(stage[RD_LATENCY-1], flush_if);
  assign pop_valid = tail.valid;
  assign pop_owner = tail.owner;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified single-port RAM between instruction fetch and the
// MEM-stage load/store port. Data wins unless IF has been denied STARVE_MAX
// cycles in a row; read responses return to their owner via a tag pipe.
module mem_port_arbiter
  import RV32I_definitions::*;
#(
  parameter int ADDR_W     = 10,
  parameter int RD_LATENCY = 1,
  parameter int STARVE_MAX = 3
) (
  input logic               Clk,
  input logic               Reset_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_cnt;
  logic                if_gnt;
  logic                d_gnt;
  logic                rd_push;
  mem_owner_t          push_owner;
  logic                pop_valid;
  mem_owner_t          pop_owner;
  logic                unused_addr_bits;

  // Grant in the request cycle; IF overrides data only once starved, and
  // nothing is granted while reset is asserted.
  always_comb begin
    if_gnt = Reset_n && bus.if_req && (!bus.d_req || starve_cnt == STARVE_LIM);
    d_gnt  = Reset_n && bus.d_req && !if_gnt;
  end

  // Count consecutive IF denials, saturating so the forced IF win stays armed.
  always_ff @(posedge Clk or negedge Reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!Reset_n)                      starve_cnt <= '0;
    else if (!bus.if_req || if_gnt)    starve_cnt <= '0;
    else if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
  end

  // Steer the winning request onto the RAM port; idle cycles drive zeros.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    bus.mem_en    = 1'b0;
    bus.mem_we    = 4'b0000;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (d_gnt) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.d_we ? bus.d_be : 4'b0000;
      bus.mem_addr  = bus.d_addr[ADDR_W+1:2];
      bus.mem_wdata = bus.d_wdata;
    end else if (if_gnt) begin
      bus.mem_en    = 1'b1;
      bus.mem_addr  = bus.if_addr[ADDR_W+1:2];
    end
  end

  // Byte offset and bits above the RAM depth play no part in addressing.
  assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                              bus.d_addr[31:ADDR_W+2], bus.d_addr[1:0]};

  assign bus.if_gnt = if_gnt;
  assign bus.d_gnt  = d_gnt;

  // Stores finish at grant; only reads occupy a slot in the tag pipe.
  assign rd_push    = if_gnt || (d_gnt && !bus.d_we);
  assign push_owner = if_gnt ? OWN_IF : OWN_D;

  mem_rd_tag_pipe #(
    .RD_LATENCY (RD_LATENCY)
  ) u_tag_pipe (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .push       (rd_push),
    .push_owner (push_owner),
    .flush_if   (bus.if_flush),
    .pop_valid  (pop_valid),
    .pop_owner  (pop_owner)
  );

  // RAM data passes straight through to the owner; the other port reads 0.
  assign bus.if_rvalid = pop_valid && (pop_owner == OWN_IF);
  assign bus.d_rvalid  = pop_valid && (pop_owner == OWN_D);
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : 32'h0;
  assign bus.d_rdata   = bus.d_rvalid  ? bus.mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus runs a reference model of
// the arbitration/memory rules and queues expected responses; a negedge
// monitor compares grants, RAM strobes and read responses against it.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 6;
  localparam int RD_LAT     = 3;
  localparam int STARVE_MAX = 3;
  localparam int DEPTH      = 1 << ADDR_W;

  typedef struct {
    logic [31:0] data;
    int          due;
  } resp_t;

  logic Clk     = 1'b0;
  logic Reset_n = 1'b0;
  int   cyc     = 0;
  int   n_vec   = 0;
  int   n_err   = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .RD_LATENCY (RD_LAT),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  // ---------------- environment RAM (sync, RD_LAT-cycle read) -------------
  logic [31:0] init_mem [DEPTH];
  logic [31:0] ram      [DEPTH];
  logic [31:0] rd_dly   [RD_LAT];

  always @(posedge Clk) begin
    rd_dly[0] <= $urandom();
    if (cyc == 0) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_mem[i];
    end else if (bus.mem_en) begin
      if (bus.mem_we == 4'b0000) rd_dly[0] <= ram[bus.mem_addr];
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
    for (int i = 1; i < RD_LAT; i++) rd_dly[i] <= rd_dly[i-1];
  end
  assign bus.mem_rdata = rd_dly[RD_LAT-1];

  // ---------------- reference model state ---------------------------------
  logic [31:0]       ref_mem [DEPTH];
  int                starve = 0;
  resp_t             if_q[$];
  resp_t             d_q[$];
  logic              exp_if_gnt = 1'b0, exp_d_gnt = 1'b0, exp_en = 1'b0;
  logic [3:0]        exp_we = 4'h0;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [31:0]       exp_wdata = 32'h0;
  logic              won_if, won_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // One request cycle: drive inputs, predict the outcome from the rules.
  task automatic drive_cycle(input logic ifr, input logic [31:0] ifa, input logic ifl,
                             input logic dr, input logic dwe, input logic [3:0] dbe,
                             input logic [31:0] da, input logic [31:0] dwd);
    int idx;
    @(posedge Clk);
    #1;
    bus.if_req = ifr; bus.if_addr = ifa; bus.if_flush = ifl;
    bus.d_req = dr; bus.d_we = dwe; bus.d_be = dbe; bus.d_addr = da; bus.d_wdata = dwd;
    // Data first, unless IF has already lost STARVE_MAX cycles in a row.
    won_if = ifr && (!dr || starve >= STARVE_MAX);
    won_d  = dr && !won_if;
    if (ifr && !won_if) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
    else                starve = 0;
    if (ifl) if_q.delete();
    idx        = won_d ? (da >> 2) % DEPTH : (ifa >> 2) % DEPTH;
    exp_if_gnt = won_if;
    exp_d_gnt  = won_d;
    exp_en     = won_if || won_d;
    exp_addr   = ADDR_W'(idx);
    exp_we     = (won_d && dwe) ? dbe : 4'h0;
    exp_wdata  = won_d ? dwd : 32'h0;
    if (won_if) if_q.push_back('{data: ref_mem[idx], due: cyc + RD_LAT});
    else if (won_d && !dwe) d_q.push_back('{data: ref_mem[idx], due: cyc + RD_LAT});
    else if (won_d) begin
      for (int b = 0; b < 4; b++)
        if (dbe[b]) ref_mem[idx][8*b +: 8] = dwd[8*b +: 8];
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_if_gnt"},    32'(bus.if_gnt),    32'h0);
    check({tag, "_d_gnt"},     32'(bus.d_gnt),     32'h0);
    check({tag, "_mem_en"},    32'(bus.mem_en),    32'h0);
    check({tag, "_mem_we"},    32'(bus.mem_we),    32'h0);
    check({tag, "_mem_addr"},  32'(bus.mem_addr),  32'h0);
    check({tag, "_mem_wdata"}, bus.mem_wdata,      32'h0);
    check({tag, "_if_rvalid"}, 32'(bus.if_rvalid), 32'h0);
    check({tag, "_d_rvalid"},  32'(bus.d_rvalid),  32'h0);
    check({tag, "_if_rdata"},  bus.if_rdata,       32'h0);
    check({tag, "_d_rdata"},   bus.d_rdata,        32'h0);
  endtask

  // ---------------- monitor: compare DUT against the scoreboard -----------
  always @(negedge Clk) begin
    logic if_due, d_due;
    if (Reset_n) begin
      check("if_gnt",    32'(bus.if_gnt), 32'(exp_if_gnt));
      check("d_gnt",     32'(bus.d_gnt),  32'(exp_d_gnt));
      check("mem_en",    32'(bus.mem_en), 32'(exp_en));
      check("mem_we",    32'(bus.mem_we), 32'(exp_we));
      check("mem_wdata", bus.mem_wdata,   exp_wdata);
      if (exp_en) check("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
      if_due = (if_q.size() != 0) && (if_q[0].due == cyc);
      d_due  = (d_q.size() != 0) && (d_q[0].due == cyc);
      check("if_rvalid", 32'(bus.if_rvalid), 32'(if_due));
      check("if_rdata",  bus.if_rdata, if_due ? if_q[0].data : 32'h0);
      check("d_rvalid",  32'(bus.d_rvalid), 32'(d_due));
      check("d_rdata",   bus.d_rdata, d_due ? d_q[0].data : 32'h0);
      if (if_due) void'(if_q.pop_front());
      if (d_due)  void'(d_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------------------------------------
  initial begin
    logic        p_if, p_d, dwe, fl;
    logic [31:0] ifa, da, dwd;
    logic [3:0]  dbe;

    for (int i = 0; i < DEPTH; i++) begin
      init_mem[i] = $urandom();
      ref_mem[i]  = init_mem[i];
    end
    bus.if_req = 1'b1; bus.if_addr = 32'h10; bus.if_flush = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'hF; bus.d_addr = 32'h20; bus.d_wdata = 32'h1;
    repeat (3) @(posedge Clk);
    #2;
    check_all_zero("reset");
    @(posedge Clk);
    #1;
    bus.if_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    Reset_n = 1'b1;

    // Single IF read at byte 0x10 lands on word 4.
    drive_cycle(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    check("t_if_addr", 32'(bus.mem_addr), 32'd4);
    idle(RD_LAT + 1);

    // Both requesting: D,D,D then the starved IF, then data again.
    for (int k = 0; k < 5; k++) begin
      drive_cycle(1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 4'h0, 32'h80 + 32'(4*k), 32'h0);
      #1;
      check("t_starve_seq", 32'(bus.if_gnt), (k == 3) ? 32'd1 : 32'd0);
    end
    idle(RD_LAT + 1);

    // Partial store then read-back of the merged word.
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 4'b0011, 32'h20, 32'hAABBCCDD);
    #1;
    check("t_store_we",   32'(bus.mem_we),   32'h3);
    check("t_store_addr", 32'(bus.mem_addr), 32'd8);
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
    check("t_merged", 32'(ref_mem[8][15:0]), 32'h0000CCDD);
    idle(RD_LAT + 1);

    // Flush kills in-flight IF reads (one retiring that cycle), not data,
    // and not an IF read granted in the flush cycle itself.
    drive_cycle(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive_cycle(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 4'h0, 32'h104, 32'h0);
    drive_cycle(1'b1, 32'h108, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive_cycle(1'b1, 32'h10C, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    idle(RD_LAT + 1);

    // Back-to-back IF, D, IF reads return in order.
    drive_cycle(1'b1, 32'h30, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive_cycle(1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 4'h0, 32'h34, 32'h0);
    drive_cycle(1'b1, 32'h38, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    idle(RD_LAT + 1);

    // Reset with two reads in flight and both requests still asserted.
    drive_cycle(1'b1, 32'h50, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive_cycle(1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 4'h0, 32'h54, 32'h0);
    @(posedge Clk);
    #1;
    bus.if_req = 1'b1; bus.d_req = 1'b1;
    Reset_n = 1'b0;
    if_q.delete(); d_q.delete(); starve = 0;
    exp_if_gnt = 1'b0; exp_d_gnt = 1'b0; exp_en = 1'b0; exp_we = 4'h0; exp_wdata = 32'h0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(posedge Clk);
    #1;
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    Reset_n = 1'b1;
    idle(RD_LAT + 2);

    // Randomized traffic; requests are held until the model grants them.
    p_if = 1'b0; p_d = 1'b0;
    ifa = 32'h0; da = 32'h0; dwd = 32'h0; dwe = 1'b0; dbe = 4'h0;
    for (int n = 0; n < 1500; n++) begin
      if (!p_if && $urandom_range(3) != 0) begin
        p_if = 1'b1; ifa = $urandom();
      end
      if (!p_d && $urandom_range(2) == 0) begin
        p_d = 1'b1; dwe = 1'($urandom_range(1)); dbe = 4'($urandom());
        da = $urandom(); dwd = $urandom();
      end
      fl = ($urandom_range(7) == 0);
      drive_cycle(p_if, ifa, fl, p_d, dwe, dbe, da, dwd);
      if (won_if) p_if = 1'b0;
      if (won_d)  p_d  = 1'b0;
    end
    idle(RD_LAT + 2);

    check("if_q_drained", 32'(if_q.size()), 32'd0);
    check("d_q_drained",  32'(d_q.size()),  32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
